// File: rtl/rc5_decrypt.sv
// ---------------------------------------------------------------------------
// rc5_decrypt
//   Iterative RC5-W/R block decryptor. One half-round pair (B then A) is
//   computed per clock, walking the subkey table from the top index down to
//   S[2], followed by a final whitening step with S[1]/S[0].
//
//   Optional build macro: RC5_ENCRYPT_EN
//     When defined, an extra `encrypt` input selects forward RC5 for the
//     accepted block (sampled at accept). Latency is identical in both
//     directions. When undefined the port does not exist.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   sub        subkey table S[0..2*ROUNDS+1], W_SIZE bits each
//   key_ready  subkey table valid
//   encrypt    (RC5_ENCRYPT_EN only) 1 = encrypt, 0 = decrypt
//   ct_in      input block, A = low word, B = high word
//   in_valid   ct_in valid
//   in_ready   block can be accepted (combinational)
//   pt_out     output block {B, A}
//   out_valid  pt_out valid, held until out_ready
//   out_ready  downstream accepts pt_out
// ---------------------------------------------------------------------------
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for a block; in_ready follows key_ready
// S_ROUND | one half-round pair per cycle, ctr counts ROUNDS down to 1
// S_FINAL | decrypt: subtract S[1]/S[0]; encrypt: pass-through
// S_DONE  | out_valid high, result held until out_ready
// ---------------------------------------------------------------------------
module rc5_decrypt #(
  parameter int W_SIZE = 16,
  parameter int ROUNDS = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2*ROUNDS+1:0][W_SIZE-1:0]      sub,
  input  logic                                 key_ready,
`ifdef RC5_ENCRYPT_EN
  input  logic                                 encrypt,
`endif
  input  logic [2*W_SIZE-1:0]                  ct_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [2*W_SIZE-1:0]                  pt_out,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int LW = $clog2(W_SIZE);
  localparam int CW = $clog2(ROUNDS + 1);
  // 2*ctr+1 <= 2*ROUNDS+1, so {ctr, bit} always lands inside the table.
  localparam int IW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [W_SIZE-1:0]   a_q, a_d;
  logic [W_SIZE-1:0]   b_q, b_d;
  logic [CW-1:0]       ctr_q, ctr_d;

  logic [IW-1:0]       k_lo, k_hi;
  logic [W_SIZE-1:0]   a_dec, b_dec;

  // Rotate via a doubled word so a shift of 0 is naturally the identity.
  function automatic logic [W_SIZE-1:0] rotr(input logic [W_SIZE-1:0] x,
                                             input logic [LW-1:0]     n);
    return W_SIZE'({x, x} >> n);
  endfunction

`ifdef RC5_ENCRYPT_EN
  localparam logic [CW-1:0] R_P1 = CW'(ROUNDS + 1);

  logic                enc_q, enc_d;
  logic [CW-1:0]       e_i;
  logic [IW-1:0]       ke_lo, ke_hi;
  logic [W_SIZE-1:0]   a_enc, b_enc;

  function automatic logic [W_SIZE-1:0] rotl(input logic [W_SIZE-1:0] x,
                                             input logic [LW-1:0]     n);
    return W_SIZE'(({x, x} << n) >> W_SIZE);
  endfunction
`endif

  // Round datapath: B' first, then A' consumes B' in the same cycle.
  always_comb begin
    k_lo  = {ctr_q, 1'b0};
    k_hi  = {ctr_q, 1'b1};
    b_dec = rotr(b_q - sub[k_hi], a_q[LW-1:0]) ^ a_q;
    a_dec = rotr(a_q - sub[k_lo], b_dec[LW-1:0]) ^ b_dec;
  end

`ifdef RC5_ENCRYPT_EN
  // Encryption walks the table upward; i = ROUNDS+1-ctr (mod 2^CW is exact
  // because i itself always fits in CW bits).
  always_comb begin
    e_i   = R_P1 - ctr_q;
    ke_lo = {e_i, 1'b0};
    ke_hi = {e_i, 1'b1};
    a_enc = rotl(a_q ^ b_q, b_q[LW-1:0]) + sub[ke_lo];
    b_enc = rotl(b_q ^ a_enc, a_enc[LW-1:0]) + sub[ke_hi];
  end
`endif

  assign in_ready  = rst & key_ready & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign pt_out    = {b_q, a_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctr_d   = ctr_q;
`ifdef RC5_ENCRYPT_EN
    enc_d   = enc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = ct_in[W_SIZE-1:0];
          b_d     = ct_in[2*W_SIZE-1:W_SIZE];
          ctr_d   = CW'(ROUNDS);
          state_d = S_ROUND;
`ifdef RC5_ENCRYPT_EN
          enc_d   = encrypt;
          if (encrypt) begin
            a_d = ct_in[W_SIZE-1:0] + sub[0];
            b_d = ct_in[2*W_SIZE-1:W_SIZE] + sub[1];
          end
`endif
        end
      end
      S_ROUND: begin
`ifdef RC5_ENCRYPT_EN
        if (enc_q) begin
          a_d = a_enc;
          b_d = b_enc;
        end else begin
          a_d = a_dec;
          b_d = b_dec;
        end
`else
        a_d = a_dec;
        b_d = b_dec;
`endif
        ctr_d = ctr_q - 1'b1;
        if (ctr_q == CW'(1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
`ifdef RC5_ENCRYPT_EN
        if (!enc_q) begin
          b_d = b_q - sub[1];
          a_d = a_q - sub[0];
        end
`else
        b_d = b_q - sub[1];
        a_d = a_q - sub[0];
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctr_q   <= '0;
`ifdef RC5_ENCRYPT_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctr_q   <= ctr_d;
`ifdef RC5_ENCRYPT_EN
      enc_q   <= enc_d;
`endif
    end
  end

endmodule
